// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter
//   Merges the line refill / write-back ports of NUM_CH caches onto one shared
//   slow-memory port. One transfer is in flight at a time:
//   IDLE (arbitrate, capture) -> GRANT (memory busy) -> RELEASE (bubble) -> IDLE.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   ch_read/ch_write    per-channel level requests, held until ch_ready
//   ch_addr/ch_wdata    per-channel line address / write line, channel i in slice i
//   ch_rdata/ch_ready   read line and completion pulse, routed to the owner only
//   mem_read/mem_write  shared memory request (registered, stable through GRANT)
//   mem_addr/mem_wdata  shared memory line address / write line
//   mem_rdata/mem_ready shared memory read line and completion pulse
//   grant_id            current (or last) owner
//   busy                high while in GRANT or RELEASE
module mem_line_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 28,
    parameter int RR_MODE = 1,
    localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
    output logic [NUM_CH*LINE_W-1:0] ch_rdata,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [LINE_W-1:0]        mem_wdata,
    input  logic [LINE_W-1:0]        mem_rdata,
    input  logic                     mem_ready,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t              state, state_nx;
    logic [NUM_CH-1:0]   req;
    logic [GW-1:0]       ptr;
    logic [GW-1:0]       win, lo_idx, hi_idx;
    logic                win_vld, hi_vld;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LINE_W-1:0]   sel_wdata;
    logic                sel_read, sel_write;

    assign req  = ch_read | ch_write;
    assign busy = (state != IDLE);

    // lo_idx: lowest requesting channel. hi_idx: lowest requesting channel
    // above the round-robin pointer. Round robin prefers hi_idx and wraps to
    // lo_idx when nothing above the pointer is requesting.
    always_comb begin : pick
        lo_idx  = '0;
        hi_idx  = '0;
        win_vld = 1'b0;
        hi_vld  = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx  = GW'(i);
                win_vld = 1'b1;
                if (i > int'(ptr)) begin
                    hi_idx = GW'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        if (RR_MODE != 0 && hi_vld) win = hi_idx;
        else                        win = lo_idx;
    end

    // Winner's request fields, captured on the IDLE -> GRANT edge.
    always_comb begin : capture_mux
        sel_addr  = '0;
        sel_wdata = '0;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win == GW'(i)) begin
                sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
                sel_read  = ch_read[i];
                sel_write = ch_write[i];
            end
        end
    end

    always_comb begin : next_state
        state_nx = state;
        case (state)
            IDLE:    if (win_vld)   state_nx = GRANT;
            GRANT:   if (mem_ready) state_nx = RELEASE;
            RELEASE:                state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // Completion is steered combinationally so the owner sees ch_ready in the
    // same cycle as mem_ready; mem_ready outside GRANT never reaches a channel.
    always_comb begin : ready_steer
        ch_ready = '0;
        ch_rdata = '0;
        if (state == GRANT && mem_ready) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (grant_id == GW'(i)) begin
                    ch_ready[i]                  = 1'b1;
                    ch_rdata[i*LINE_W +: LINE_W] = mem_rdata;
                end
            end
        end
    end

    // The mem_* registers double as the holding registers, so a channel that
    // withdraws its request mid-transfer cannot disturb the memory port.
    // A write masks a simultaneous read; the read is served in a later round.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_id  <= '0;
            ptr       <= GW'(NUM_CH - 1);
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant_id  <= win;
                        ptr       <= win;
                        mem_read  <= sel_read & ~sel_write;
                        mem_write <= sel_write;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                    end
                end
                GRANT: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter
//   Directed bench for mem_line_arbiter. Instance a: 2 channels, round robin.
//   Instance b: 2 channels, fixed priority. Instance c: 3 channels, round robin.
module tb_mem_line_arbiter;

    localparam int LW = 128;
    localparam int AW = 28;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // instance a
    logic [1:0]      a_rd, a_wr, a_rdy;
    logic [2*AW-1:0] a_addr;
    logic [2*LW-1:0] a_wdata, a_rdata;
    logic            a_mrd, a_mwr, a_mready, a_busy;
    logic [AW-1:0]   a_maddr;
    logic [LW-1:0]   a_mwdata, a_mrdata;
    logic [0:0]      a_gid;

    // instance b
    logic [1:0]      b_rd, b_wr, b_rdy;
    logic [2*AW-1:0] b_addr;
    logic [2*LW-1:0] b_wdata, b_rdata;
    logic            b_mrd, b_mwr, b_mready, b_busy;
    logic [AW-1:0]   b_maddr;
    logic [LW-1:0]   b_mwdata, b_mrdata;
    logic [0:0]      b_gid;

    // instance c
    logic [2:0]      c_rd, c_wr, c_rdy;
    logic [3*AW-1:0] c_addr;
    logic [3*LW-1:0] c_wdata, c_rdata;
    logic            c_mrd, c_mwr, c_mready, c_busy;
    logic [AW-1:0]   c_maddr;
    logic [LW-1:0]   c_mwdata, c_mrdata;
    logic [1:0]      c_gid;

    mem_line_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ch_read(a_rd), .ch_write(a_wr), .ch_addr(a_addr),
        .ch_wdata(a_wdata), .ch_rdata(a_rdata), .ch_ready(a_rdy), .mem_read(a_mrd),
        .mem_write(a_mwr), .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_rdata(a_mrdata),
        .mem_ready(a_mready), .grant_id(a_gid), .busy(a_busy));

    mem_line_arbiter #(.NUM_CH(2), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .ch_read(b_rd), .ch_write(b_wr), .ch_addr(b_addr),
        .ch_wdata(b_wdata), .ch_rdata(b_rdata), .ch_ready(b_rdy), .mem_read(b_mrd),
        .mem_write(b_mwr), .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_rdata(b_mrdata),
        .mem_ready(b_mready), .grant_id(b_gid), .busy(b_busy));

    mem_line_arbiter #(.NUM_CH(3), .LINE_W(LW), .ADDR_W(AW), .RR_MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .ch_read(c_rd), .ch_write(c_wr), .ch_addr(c_addr),
        .ch_wdata(c_wdata), .ch_rdata(c_rdata), .ch_ready(c_rdy), .mem_read(c_mrd),
        .mem_write(c_mwr), .mem_addr(c_maddr), .mem_wdata(c_mwdata), .mem_rdata(c_mrdata),
        .mem_ready(c_mready), .grant_id(c_gid), .busy(c_busy));

    typedef struct {
        logic          ch;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t sbq[$];
    txn_t a_cur;
    int   gq[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request on instance a and push the transfer the memory port should see.
    task automatic a_req(input logic ch, input logic rd, input logic wr,
                         input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
        txn_t t;
        a_rd[ch] = rd;
        a_wr[ch] = wr;
        if (ch) begin
            a_addr[2*AW-1:AW]  = addr;
            a_wdata[2*LW-1:LW] = wdata;
        end else begin
            a_addr[AW-1:0]  = addr;
            a_wdata[LW-1:0] = wdata;
        end
        t.ch = ch; t.rd = rd & ~wr; t.wr = wr; t.addr = addr; t.wdata = wdata;
        sbq.push_back(t);
    endtask

    // Wait (bounded) for the memory request, pop the scoreboard and compare.
    task automatic a_grant(output int n);
        n = 0;
        while (!(a_mrd || a_mwr) && n < 20) begin
            tick();
            n++;
        end
        chk("a_grant_seen", 256'(n < 20), 256'(1));
        chk("a_sb_nonempty", 256'(sbq.size() != 0), 256'(1));
        if (sbq.size() != 0) begin
            a_cur = sbq.pop_front();
            chk("a_mem_rw", {a_mrd, a_mwr}, {a_cur.rd, a_cur.wr});
            chk("a_mem_addr", a_maddr, a_cur.addr);
            if (a_cur.wr) chk("a_mem_wdata", a_mwdata, a_cur.wdata);
            chk("a_grant_id", a_gid, a_cur.ch);
            chk("a_busy_grant", a_busy, 1'b1);
        end
    endtask

    // Hold for a few cycles, pulse mem_ready, check steering and the bubble.
    task automatic a_finish(input int delay, input logic [LW-1:0] rdata, input logic drop);
        logic [2*LW-1:0] exp_rdata;
        repeat (delay) tick();
        chk("a_hold_rw", {a_mrd, a_mwr}, {a_cur.rd, a_cur.wr});
        chk("a_hold_addr", a_maddr, a_cur.addr);
        a_mrdata = rdata;
        a_mready = 1'b1;
        #1;
        exp_rdata = '0;
        if (a_cur.ch) exp_rdata[2*LW-1:LW] = rdata;
        else          exp_rdata[LW-1:0]    = rdata;
        chk("a_ch_ready", a_rdy, a_cur.ch ? 2'b10 : 2'b01);
        chk("a_ch_rdata", a_rdata, exp_rdata);
        tick();
        a_mready = 1'b0;
        a_mrdata = '0;
        if (drop) begin
            a_rd[a_cur.ch] = 1'b0;
            a_wr[a_cur.ch] = 1'b0;
        end
        #1;
        chk("a_release_rw", {a_mrd, a_mwr}, 2'b00);
        chk("a_release_ready", a_rdy, 2'b00);
        chk("a_release_busy", a_busy, 1'b1);
    endtask

    task automatic a_zero_outputs(input string tag);
        chk({tag, "_rw"}, {a_mrd, a_mwr}, 2'b00);
        chk({tag, "_addr"}, a_maddr, '0);
        chk({tag, "_wdata"}, a_mwdata, '0);
        chk({tag, "_ready"}, a_rdy, 2'b00);
        chk({tag, "_rdata"}, a_rdata, '0);
        chk({tag, "_gid"}, a_gid, 1'b0);
        chk({tag, "_busy"}, a_busy, 1'b0);
    endtask

    initial begin
        int n;
        a_rd = '0; a_wr = '0; a_addr = '0; a_wdata = '0; a_mrdata = '0; a_mready = 1'b0;
        b_rd = '0; b_wr = '0; b_addr = '0; b_wdata = '0; b_mrdata = '0; b_mready = 1'b0;
        c_rd = '0; c_wr = '0; c_addr = '0; c_wdata = '0; c_mrdata = '0; c_mready = 1'b0;

        // reset state
        #12;
        a_zero_outputs("rst");
        chk("rst_b_busy", b_busy, 1'b0);
        chk("rst_c_gid", c_gid, 2'b00);
        rst_n = 1'b1;
        tick();

        // T1: single read on ch1, one-cycle request latency
        a_req(1'b1, 1'b1, 1'b0, 28'h0000010, '0);
        chk("t1_no_early_req", a_mrd, 1'b0);
        a_grant(n);
        chk("t1_latency", 256'(n), 256'(1));
        a_finish(5, {16{8'hA5}}, 1'b1);

        // T2: simultaneous requests after reset; ch0 first, ch1 write 3 cycles after ready
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        a_req(1'b0, 1'b1, 1'b0, 28'h0000100, '0);
        a_req(1'b1, 1'b0, 1'b1, 28'h0000200, {4{32'hDEADBEEF}});
        a_grant(n);
        a_finish(2, {4{32'h12345678}}, 1'b1);
        a_grant(n);
        chk("t2_gap", 256'(n), 256'(2));
        a_finish(1, {4{32'h0BADF00D}}, 1'b1);

        // write masks a simultaneous read; the held read is served next round
        a_req(1'b0, 1'b1, 1'b1, 28'h0000500, {4{32'hCAFEF00D}});
        a_grant(n);
        a_finish(1, '0, 1'b0);
        a_req(1'b0, 1'b1, 1'b0, 28'h0000500, '0);
        a_grant(n);
        chk("prec_gap", 256'(n), 256'(2));
        a_finish(2, {8{16'h5A5A}}, 1'b1);

        // T5: dirty miss on ch1, write-back then refill
        a_req(1'b1, 1'b0, 1'b1, 28'h0000300, 128'h0123456789ABCDEF_FEDCBA9876543210);
        a_grant(n);
        a_finish(3, '0, 1'b1);
        a_req(1'b1, 1'b1, 1'b0, 28'h0000400, '0);
        a_grant(n);
        chk("t5_bubble", 256'(n), 256'(2));
        a_finish(2, {4{32'h7777AAAA}}, 1'b1);

        // request withdrawn during GRANT still completes
        a_req(1'b0, 1'b1, 1'b0, 28'h0000600, '0);
        a_grant(n);
        a_rd[0] = 1'b0;
        a_finish(3, {4{32'h600D600D}}, 1'b1);

        // mem_ready outside GRANT is ignored
        a_mready = 1'b1;
        #1;
        chk("stray_ready_release", a_rdy, 2'b00);
        tick();
        chk("stray_ready_idle", a_rdy, 2'b00);
        chk("stray_ready_busy", a_busy, 1'b0);
        a_mready = 1'b0;

        // T6: asynchronous reset in the middle of GRANT
        a_req(1'b0, 1'b1, 1'b0, 28'h0000700, '0);
        a_grant(n);
        #2;
        rst_n = 1'b0;
        #1;
        a_zero_outputs("t6_async");
        a_rd = '0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_mready = 1'b1;
            a_mrdata = {4{32'hFFFF0000}};
            #1;
            chk("t6_no_ready", a_rdy, 2'b00);
            chk("t6_idle_busy", a_busy, 1'b0);
            chk("t6_idle_rw", {a_mrd, a_mwr}, 2'b00);
            tick();
        end
        a_mready = 1'b0;
        a_mrdata = '0;

        // T3: fixed priority, ch0 keeps requesting, ch1 starves
        b_addr = {28'h0000222, 28'h0000111};
        b_rd   = 2'b11;
        for (int x = 0; x < 10; x++) begin
            gq.push_back(0);
            n = 0;
            while (!b_mrd && n < 20) begin
                tick();
                n++;
            end
            chk("t3_grant_seen", 256'(n < 20), 256'(1));
            chk("t3_gid", b_gid, 256'(gq.pop_front()));
            chk("t3_addr", b_maddr, 28'h0000111);
            b_mready = 1'b1;
            #1;
            chk("t3_ready", b_rdy, 2'b01);
            tick();
            b_mready = 1'b0;
        end
        b_rd = '0;

        // T4: three channels requesting continuously, round robin with wrap
        c_addr = {28'h0000003, 28'h0000002, 28'h0000001};
        c_rd   = 3'b111;
        gq = '{0, 1, 2, 0, 1};
        for (int x = 0; x < 5; x++) begin
            int e;
            e = gq.pop_front();
            n = 0;
            while (!c_mrd && n < 20) begin
                tick();
                n++;
            end
            chk("t4_grant_seen", 256'(n < 20), 256'(1));
            chk("t4_gid", c_gid, 256'(e));
            chk("t4_addr", c_maddr, 256'(e + 1));
            c_mready = 1'b1;
            #1;
            chk("t4_ready", c_rdy, 256'(1 << e));
            tick();
            c_mready = 1'b0;
        end
        c_rd = '0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
